t5_load: RTL and testbench

- Memory-return stage directly downstream of the data-bus request stage.
- Consumes the data-bus response (`dwb_dti`/`dwb_ack`) for the access the request stage has placed on the bus.
- Stalls the pipeline until the access completes or times out.
- Aligns and sign/zero-extends load data and presents a registered register-file writeback (data, destination, enable) to the writeback stage.

---
 rtl/t5_load.sv | 125 ++++++++++++
 tb/tb_t5_load.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/t5_load.sv
// Memory-return stage: waits for the data-bus acknowledge of the access placed by
// the request stage, aborts on timeout, and registers the aligned load writeback.
module t5_load #(
  parameter int XLEN = 32,
  parameter int TOUT = 15,
  parameter int TW   = 8
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic [XLEN-1:0] dwb_dti,
  input  logic            dwb_ack,
  input  logic            xstb,
  input  logic            xwre,
  input  logic [1:0]      xoff,
  input  logic [2:0]      xfn3,
  input  logic [4:0]      xrd,
  output logic            dstall,
  output logic [XLEN-1:0] mdat,
  output logic [4:0]      mrd,
  output logic            mwre,
  output logic            merr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  localparam logic [TW-1:0] TOUT_C = TW'(TOUT);

  logic [0:0]      state_q, state_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mdat_q, mdat_d;
  logic [4:0]      mrd_q, mrd_d;
  logic            mwre_q, mwre_d;
  logic            merr_q, merr_d;

  logic            toutHit;
  logic            complete;
  logic            abort;
  logic [7:0]      laneByte;
  logic [15:0]     laneHalf;
  logic [XLEN-1:0] aligned;

  assign toutHit  = (state_q == WAIT) && (cnt_q == TOUT_C);
  assign complete = xstb & dwb_ack;
  // Ack wins over a coincident timeout, so abort requires no ack this cycle.
  assign abort    = xstb & ~dwb_ack & toutHit;
  assign dstall   = srst & xstb & ~dwb_ack & ~toutHit;

  always_comb begin
    laneByte = dwb_dti[7:0];
    case (xoff)
      2'd0:    laneByte = dwb_dti[7:0];
      2'd1:    laneByte = dwb_dti[15:8];
      2'd2:    laneByte = dwb_dti[23:16];
      default: laneByte = dwb_dti[31:24];
    endcase
    laneHalf = xoff[1] ? dwb_dti[31:16] : dwb_dti[15:0];
    case (xfn3)
      3'b000:  aligned = {{(XLEN-8){laneByte[7]}}, laneByte};
      3'b100:  aligned = {{(XLEN-8){1'b0}}, laneByte};
      3'b001:  aligned = {{(XLEN-16){laneHalf[15]}}, laneHalf};
      3'b101:  aligned = {{(XLEN-16){1'b0}}, laneHalf};
      default: aligned = dwb_dti;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (xstb && !dwb_ack) begin
          state_d = WAIT;
          cnt_d   = TW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      WAIT: begin
        if (!xstb || dwb_ack || toutHit) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Stores still refresh mdat/mrd; only the write enable is suppressed.
  always_comb begin
    mwre_d = complete & ~xwre & (xrd != 5'd0);
    merr_d = abort;
    mdat_d = complete ? aligned : mdat_q;
    mrd_d  = complete ? xrd : mrd_q;
  end

  always_ff @(posedge sclk or negedge srst) begin
    if (!srst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mdat_q  <= '0;
      mrd_q   <= '0;
      mwre_q  <= 1'b0;
      merr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mdat_q  <= mdat_d;
      mrd_q   <= mrd_d;
      mwre_q  <= mwre_d;
      merr_q  <= merr_d;
    end
  end

  assign mdat = mdat_q;
  assign mrd  = mrd_q;
  assign mwre = mwre_q;
  assign merr = merr_q;

endmodule

// File: tb/tb_t5_load.sv
// Scoreboard bench for t5_load: stimulus pushes expected writeback/abort pulses,
// a negedge monitor pops and compares whenever mwre or merr is presented.
module tb_t5_load;

  logic        sclk;
  logic        srst;
  logic [31:0] dwb_dti;
  logic        dwb_ack;
  logic        xstb;
  logic        xwre;
  logic [1:0]  xoff;
  logic [2:0]  xfn3;
  logic [4:0]  xrd;
  logic        dstall;
  logic [31:0] mdat;
  logic [4:0]  mrd;
  logic        mwre;
  logic        merr;

  typedef struct packed {
    logic        isErr;
    logic [31:0] dat;
    logic [4:0]  rd;
  } expT;

  expT sbQ[$];
  int  vecCount;
  int  missCount;

  t5_load #(.XLEN(32), .TOUT(15), .TW(8)) dut (
    .sclk    (sclk),
    .srst    (srst),
    .dwb_dti (dwb_dti),
    .dwb_ack (dwb_ack),
    .xstb    (xstb),
    .xwre    (xwre),
    .xoff    (xoff),
    .xfn3    (xfn3),
    .xrd     (xrd),
    .dstall  (dstall),
    .mdat    (mdat),
    .mrd     (mrd),
    .mwre    (mwre),
    .merr    (merr)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic stb, input logic wre, input logic [1:0] off,
                               input logic [2:0] fn3, input logic [4:0] rd,
                               input logic [31:0] dti, input logic ack);
    xstb    = stb;
    xwre    = wre;
    xoff    = off;
    xfn3    = fn3;
    xrd     = rd;
    dwb_dti = dti;
    dwb_ack = ack;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge sclk);
    #1;
  endtask

  task automatic pushLoad(input logic [31:0] dat, input logic [4:0] rd);
    expT e;
    e.isErr = 1'b0;
    e.dat   = dat;
    e.rd    = rd;
    sbQ.push_back(e);
  endtask

  task automatic pushAbort(input logic [31:0] heldDat, input logic [4:0] heldRd);
    expT e;
    e.isErr = 1'b1;
    e.dat   = heldDat;
    e.rd    = heldRd;
    sbQ.push_back(e);
  endtask

  // Any pulse without a matching entry, or a pulse lasting two cycles, is a miscompare.
  always @(negedge sclk) begin
    expT e;
    if (mwre === 1'b1 || merr === 1'b1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected pulse {merr,mwre}", {30'b0, merr, mwre}, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("pulse {merr,mwre}", {30'b0, merr, mwre}, e.isErr ? 32'd2 : 32'd1);
        checkOutput("mdat", mdat, e.dat);
        checkOutput("mrd", {27'b0, mrd}, {27'b0, e.rd});
      end
    end
  end

  initial begin
    vecCount  = 0;
    missCount = 0;
    srst = 1'b1;
    applyStimulus(1'b1, 1'b0, 2'd0, 3'b010, 5'd1, 32'h0, 1'b0);
    srst = 1'b0;
    #2;
    checkOutput("reset dstall", {31'b0, dstall}, 32'd0);
    checkOutput("reset mdat", mdat, 32'd0);
    checkOutput("reset mrd", {27'b0, mrd}, 32'd0);
    checkOutput("reset mwre/merr", {30'b0, merr, mwre}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b000, 5'd0, 32'h0, 1'b0);
    repeat (2) @(posedge sclk);
    #1 srst = 1'b1;
    nextCycle();

    // LB sign-extended, acked immediately
    applyStimulus(1'b1, 1'b0, 2'd2, 3'b000, 5'd5, 32'h1280_3456, 1'b1);
    checkOutput("LB dstall", {31'b0, dstall}, 32'd0);
    pushLoad(32'hFFFF_FF80, 5'd5);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b000, 5'd0, 32'h0, 1'b0);
    nextCycle();

    // LHU upper half with ack on the third cycle
    applyStimulus(1'b1, 1'b0, 2'd2, 3'b101, 5'd7, 32'hBEEF_0000, 1'b0);
    checkOutput("LHU dstall c1", {31'b0, dstall}, 32'd1);
    nextCycle();
    checkOutput("LHU dstall c2", {31'b0, dstall}, 32'd1);
    nextCycle();
    dwb_ack = 1'b1;
    #1;
    checkOutput("LHU dstall ack", {31'b0, dstall}, 32'd0);
    pushLoad(32'h0000_BEEF, 5'd7);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b000, 5'd0, 32'h0, 1'b0);
    nextCycle();

    // Timeout: 15 stalled cycles, then abort with mdat/mrd held
    applyStimulus(1'b1, 1'b0, 2'd0, 3'b010, 5'd9, 32'hDEAD_BEEF, 1'b0);
    for (int i = 0; i < 15; i++) begin
      checkOutput($sformatf("timeout dstall c%0d", i + 1), {31'b0, dstall}, 32'd1);
      nextCycle();
    end
    checkOutput("timeout dstall c16", {31'b0, dstall}, 32'd0);
    pushAbort(32'h0000_BEEF, 5'd7);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b000, 5'd0, 32'h0, 1'b0);
    nextCycle();

    // Ack coincident with the timeout cycle: completion wins
    applyStimulus(1'b1, 1'b0, 2'd1, 3'b000, 5'd3, 32'hAB00_7F00, 1'b0);
    repeat (15) nextCycle();
    dwb_ack = 1'b1;
    #1;
    checkOutput("coincident dstall", {31'b0, dstall}, 32'd0);
    pushLoad(32'h0000_007F, 5'd3);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b000, 5'd0, 32'h0, 1'b0);
    nextCycle();

    // Store: no write enable, but mdat/mrd refresh
    applyStimulus(1'b1, 1'b1, 2'd0, 3'b010, 5'd4, 32'h1122_3344, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b000, 5'd0, 32'h0, 1'b0);
    checkOutput("store mwre", {31'b0, mwre}, 32'd0);
    checkOutput("store mdat", mdat, 32'h1122_3344);
    checkOutput("store mrd", {27'b0, mrd}, 32'd4);
    nextCycle();

    // Load to x0: no write enable
    applyStimulus(1'b1, 1'b0, 2'd0, 3'b010, 5'd0, 32'hCAFE_F00D, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b000, 5'd0, 32'h0, 1'b0);
    checkOutput("rd0 mwre", {31'b0, mwre}, 32'd0);
    checkOutput("rd0 mdat", mdat, 32'hCAFE_F00D);
    checkOutput("rd0 mrd", {27'b0, mrd}, 32'd0);
    nextCycle();

    // Back-to-back immediate acks, including misaligned half/word offsets
    applyStimulus(1'b1, 1'b0, 2'd3, 3'b001, 5'd10, 32'h8001_1234, 1'b1);
    pushLoad(32'hFFFF_8001, 5'd10);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 2'd3, 3'b100, 5'd11, 32'h9A00_0000, 1'b1);
    pushLoad(32'h0000_009A, 5'd11);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 2'd2, 3'b010, 5'd12, 32'h0123_4567, 1'b1);
    pushLoad(32'h0123_4567, 5'd12);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 2'd0, 3'b001, 5'd16, 32'h0000_8765, 1'b1);
    pushLoad(32'hFFFF_8765, 5'd16);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 2'd1, 3'b110, 5'd13, 32'h7654_3210, 1'b1);
    pushLoad(32'h7654_3210, 5'd13);
    nextCycle();

    // Ack without a strobe is ignored
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b010, 5'd14, 32'hFFFF_FFFF, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b000, 5'd0, 32'h0, 1'b0);
    checkOutput("stray ack mrd", {27'b0, mrd}, 32'd13);
    checkOutput("stray ack mdat", mdat, 32'h7654_3210);
    nextCycle();

    // Asynchronous reset while waiting with cnt=7
    applyStimulus(1'b1, 1'b0, 2'd0, 3'b010, 5'd15, 32'h5555_AAAA, 1'b0);
    repeat (7) nextCycle();
    #2 srst = 1'b0;
    #1;
    checkOutput("midwait reset dstall", {31'b0, dstall}, 32'd0);
    checkOutput("midwait reset mdat", mdat, 32'd0);
    checkOutput("midwait reset mrd", {27'b0, mrd}, 32'd0);
    checkOutput("midwait reset mwre/merr", {30'b0, merr, mwre}, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 3'b000, 5'd0, 32'h0, 1'b0);
    @(posedge sclk);
    #1 srst = 1'b1;
    repeat (20) nextCycle();
    checkOutput("post reset dstall", {31'b0, dstall}, 32'd0);

    checkOutput("scoreboard leftover", sbQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
